// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and constants for the SRAM access arbiter.
// Optional build macro used by this slice: SRAM_ARB_FIXED_PRIO_EN.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2,
    S_TURN   = 2'd3
  } state_t;

  // Pin levels presented to the SRAM whenever no access is in flight
  localparam logic SRAM_WE_N_IDLE  = 1'b1;
  localparam logic SRAM_BITS_IDLE  = 1'b0;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side command/response bundle between effect blocks and the arbiter.
// Requester k's address and write data sit at [k*W +: W] of the packed vectors.
interface sram_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we_n;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, we_n, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we_n, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational winner selection: round-robin from ptr, or requester 0 first
// with round-robin among the rest when SRAM_ARB_FIXED_PRIO_EN is defined.
module rr_priority_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] req_rr;

  always_comb begin
    int cand;
    cand    = 0;
    req_rr  = req;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Playback requester pre-empts the rotation; it never joins the rr scan
    req_rr[0] = 1'b0;
    if (req[0]) begin
      gnt_oh[0] = 1'b1;
      any       = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!any && req_rr[cand]) begin
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IDX_W'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Serialises one-word requester commands onto the single external SRAM.
// Build option: SRAM_ARB_FIXED_PRIO_EN (requester 0 always wins when asking).
//
// state    | meaning
// S_IDLE   | pins parked; arbitrate and latch the winner's command
// S_ACCESS | drive latched addr/we_n/wdata for one cycle
// S_READ   | hold addr for RD_LAT cycles, sample read data on the last
// S_TURN   | write recovery cycle, we_n high, addr/wdata held
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sram_access_arbiter_if.slave bus,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, pick_idx, lat_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any;
  logic               lat_we_n;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [1:0]         rd_cnt;
  logic               rd_last;

  assign rd_last = (rd_cnt == 2'd0);

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pick_any) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = lat_we_n ? S_READ : S_TURN;
      S_READ:   if (rd_last) state_nxt = S_IDLE;
      S_TURN:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Pins are decoded from state so an async reset parks them (we_n high) at once
  always_comb begin
    o_busy       = (state != S_IDLE);
    o_sram_addr  = {ADDR_W{SRAM_BITS_IDLE}};
    o_sram_we_n  = SRAM_WE_N_IDLE;
    o_sram_wdata = {DATA_W{SRAM_BITS_IDLE}};
    case (state)
      S_ACCESS: begin
        o_sram_addr  = lat_addr;
        o_sram_we_n  = lat_we_n;
        o_sram_wdata = lat_we_n ? '0 : lat_wdata;
      end
      S_READ:   o_sram_addr = lat_addr;
      S_TURN: begin
        o_sram_addr  = lat_addr;
        o_sram_wdata = lat_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr     <= '0;
      lat_idx    <= '0;
      lat_we_n   <= 1'b1;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_cnt     <= '0;
      bus.gnt    <= '0;
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.gnt    <= '0;
      bus.rvalid <= '0;
      case (state)
        S_IDLE: if (pick_any) begin
          lat_idx   <= pick_idx;
          lat_we_n  <= bus.we_n[pick_idx];
          lat_addr  <= bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          lat_wdata <= bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
          bus.gnt   <= pick_oh;
          rr_ptr    <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
        end
        S_ACCESS: rd_cnt <= 2'(RD_LAT-1);
        S_READ: begin
          if (rd_last) begin
            bus.rdata  <= i_sram_rdata;
            bus.rvalid <= NUM_REQ'(1) << lat_idx;
          end else begin
            rd_cnt <= rd_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a cycle-level reference model
// predicts grants, read data and SRAM pin levels; a monitor pops and compares.
`timescale 1ns/1ps
module tb_sram_access_arbiter;

  localparam int N = 3, AW = 20, DW = 16, RD_LAT = 1;
  localparam logic [AW-1:0] ADDR_TAB [8] = '{20'h07D00, 20'h05000, 20'hFFFFF, 20'h00001,
                                             20'h80000, 20'h12345, 20'h40000, 20'h00000};

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic o_busy, o_sram_we_n;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wdata, i_sram_rdata;

  sram_access_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  sram_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus), .o_busy(o_busy),
    .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // SRAM device model: only the table addresses exist
  logic [DW-1:0] sram_mem [8] = '{default: '0};
  always_comb begin
    i_sram_rdata = 16'hDEAD;
    for (int i = 0; i < 8; i++) if (o_sram_addr == ADDR_TAB[i]) i_sram_rdata = sram_mem[i];
  end
  always @(posedge i_clk)
    if (!o_sram_we_n)
      for (int i = 0; i < 8; i++) if (o_sram_addr == ADDR_TAB[i]) sram_mem[i] <= o_sram_wdata;

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout/absent required event (cycle %0d)", name, cyc);
  endtask

  typedef struct { int cyc; bit is_rd; int idx; logic [DW-1:0] data; } ev_t;
  ev_t exp_q[$];
  int  gnt_log[$];

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int start);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      int c = (start + i) % N;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      if (c != 0 && r[c]) return c;
`else
      if (r[c]) return c;
`endif
    end
    return -1;
  endfunction

  // Reference model: arbitration decisions, memory contents and pin timeline
  logic [DW-1:0] ref_mem [int];
  int            next_dec = 0, cur_d = -100, ptr = 0, m_w;
  bit            cur_we_n = 1'b1, prev_wlow = 1'b0, e_busy, e_we;
  logic [AW-1:0] cur_addr = '0, e_addr;
  logic [DW-1:0] cur_wdata = '0, e_wd, rd_exp;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("reset_pins", {o_busy, o_sram_addr, o_sram_we_n, o_sram_wdata}, {1'b0, 20'h0, 1'b1, 16'h0});
      exp_q.delete();
      next_dec = 0; cur_d = -100; ptr = 0; prev_wlow = 1'b0;
    end else begin
      e_busy = (cyc < next_dec);
      if (e_busy) begin
        e_addr = cur_addr;
        e_we   = !((cyc - cur_d) == 1 && !cur_we_n);
        e_wd   = cur_we_n ? '0 : cur_wdata;
      end else begin
        e_addr = '0; e_we = 1'b1; e_wd = '0;
      end
      chk("pins", {o_busy, o_sram_addr, o_sram_we_n, o_sram_wdata}, {e_busy, e_addr, e_we, e_wd});
      if (!o_sram_we_n) chk("we_gap", prev_wlow, 1'b0);
      prev_wlow = !o_sram_we_n;
      if (!e_busy && bus.req != '0) begin
        m_w       = pick(bus.req, ptr);
        ptr       = (m_w + 1) % N;
        cur_d     = cyc;
        cur_we_n  = bus.we_n[m_w];
        cur_addr  = bus.addr[m_w*AW +: AW];
        cur_wdata = bus.wdata[m_w*DW +: DW];
        exp_q.push_back('{cyc + 1, 1'b0, m_w, '0});
        if (cur_we_n) begin
          rd_exp = ref_mem.exists(int'(cur_addr)) ? ref_mem[int'(cur_addr)] : '0;
          exp_q.push_back('{cyc + 2 + RD_LAT, 1'b1, m_w, rd_exp});
          next_dec = cyc + 2 + RD_LAT;
        end else begin
          ref_mem[int'(cur_addr)] = cur_wdata;
          next_dec = cyc + 3;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents gnt/rvalid
  logic [DW-1:0] exp_rdata = '0;
  ev_t mon_e;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("reset_outs", {bus.gnt, bus.rvalid, bus.rdata}, '0);
      exp_rdata = '0;
    end else begin
      if (bus.rvalid != '0) begin
        if (exp_q.size() == 0 || !exp_q[0].is_rd) chk("unexpected_rvalid", bus.rvalid, '0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rvalid", {cyc, bus.rvalid, bus.rdata}, {mon_e.cyc, oh(mon_e.idx), mon_e.data});
          exp_rdata = mon_e.data;
        end
      end
      if (bus.gnt != '0) begin
        for (int i = 0; i < N; i++) if (bus.gnt[i]) begin gnt_log.push_back(i); break; end
        if (exp_q.size() == 0 || exp_q[0].is_rd) chk("unexpected_gnt", bus.gnt, '0);
        else begin
          mon_e = exp_q.pop_front();
          chk("gnt", {cyc, bus.gnt}, {mon_e.cyc, oh(mon_e.idx)});
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        fail_now(mon_e.is_rd ? "missing_rvalid" : "missing_gnt");
      end
      chk("rdata_hold", bus.rdata, exp_rdata);
    end
  end

  task automatic set_cmd(input int k, input bit we_n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we_n[k]           = we_n;
    bus.addr[k*AW +: AW]  = a;
    bus.wdata[k*DW +: DW] = d;
  endtask

  // Called at posedge+1; returns at posedge+1 of the grant cycle with req still high
  task automatic issue(input int k, input bit we_n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_cmd(k, we_n, a, d);
    bus.req[k] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge i_clk); #1;
      if (bus.gnt[k]) return;
    end
    fail_now("issue_timeout");
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge i_clk); #1;
      for (int k = 0; k < N; k++) if (bus.gnt[k]) bus.req[k] = 1'b0;
      if (bus.req == '0) return;
    end
    fail_now("drain_timeout");
  endtask

  task automatic wait_grants(input int n, input string name);
    for (int t = 0; t < 100; t++) begin
      if (gnt_log.size() >= n) return;
      @(posedge i_clk); #1;
    end
    fail_now(name);
  endtask

  int exp_order [6];

  initial begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    bus.req = '0; bus.we_n = '1; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    idle_wait(1);

    // contention from reset: all requesters held high
    gnt_log.delete();
    for (int k = 0; k < N; k++) set_cmd(k, 1'b0, ADDR_TAB[k+2], 16'hA000 + 16'(k));
    bus.req = '1;
    wait_grants(6, "contention_timeout");
    for (int i = 0; i < 6; i++)
      if (i < gnt_log.size()) chk("contention_order", gnt_log[i], exp_order[i]);
    drain();
    idle_wait(6);

    // single write then single read of the same word
    issue(0, 1'b0, 20'h07D00, 16'h1234);
    bus.req[0] = 1'b0;
    idle_wait(6);
    issue(1, 1'b1, 20'h07D00, 16'h0);
    bus.req[1] = 1'b0;
    idle_wait(6);

    // back-to-back write/read on one requester
    for (int i = 0; i < 6; i++) issue(2, 1'(i % 2), 20'h05000, 16'hBEEF);
    bus.req[2] = 1'b0;
    idle_wait(6);

    // random traffic
    for (int t = 0; t < 600; t++) begin
      @(posedge i_clk); #1;
      for (int k = 0; k < N; k++) begin
        if (bus.gnt[k] || !bus.req[k]) begin
          if (bus.gnt[k] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0)) begin
            set_cmd(k, 1'($urandom_range(0, 1)), ADDR_TAB[$urandom_range(0, 7)], 16'($urandom));
            bus.req[k] = 1'b1;
          end else begin
            bus.req[k] = 1'b0;
          end
        end
      end
    end
    drain();
    idle_wait(8);

    // reset in the middle of a read from requester 0
    issue(0, 1'b1, 20'h07D00, 16'h0);
    bus.req[0] = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    idle_wait(1);
    gnt_log.delete();
    set_cmd(0, 1'b0, ADDR_TAB[3], 16'h5A5A);
    set_cmd(1, 1'b0, ADDR_TAB[4], 16'hA5A5);
    bus.req = 3'b011;
    wait_grants(1, "post_reset_timeout");
    if (gnt_log.size() > 0) chk("post_reset_first", gnt_log[0], 0);
    drain();
    idle_wait(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
